// File: rtl/gate_pkg.sv
// Op encoding and gate function for the simple-gate pipeline.
// Operands are carried at GATE_MAX_W; callers zero-extend and keep the low WIDTH bits.
package gate_pkg;

  localparam int unsigned GATE_OP_W  = 2;
  localparam int unsigned GATE_MAX_W = 1024;

  typedef enum logic [GATE_OP_W-1:0] {
    GATE_INV   = 2'd0,
    GATE_AND2  = 2'd1,
    GATE_NAND2 = 2'd2,
    GATE_MUX2  = 2'd3
  } gate_op_e;

  typedef logic [GATE_MAX_W-1:0] gate_word_t;

  function automatic gate_word_t gate_eval(gate_op_e op, gate_word_t a, gate_word_t b, logic s);
    gate_word_t r;
    case (op)
      GATE_INV:   r = ~a;
      GATE_AND2:  r = a & b;
      GATE_NAND2: r = ~(a & b);
      GATE_MUX2:  r = s ? b : a;
      default:    r = a;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/gate_pipe_slice.sv
// One elastic register slice: valid/op/data with ready flowing upstream.
// The slot is free when empty or when its content is consumed this cycle.
module gate_pipe_slice
  import gate_pkg::*;
#(
  parameter int unsigned Width = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  gate_op_e         in_op_i,
  input  logic [Width-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output gate_op_e         out_op_o,
  output logic [Width-1:0] out_data_o
);

  logic             valid_q, valid_d;
  gate_op_e         op_q, op_d;
  logic [Width-1:0] data_q, data_d;

  assign in_ready_o  = !valid_q || out_ready_i;
  assign out_valid_o = valid_q;
  assign out_op_o    = op_q;
  assign out_data_o  = data_q;

  always_comb begin
    valid_d = valid_q;
    op_d    = op_q;
    data_d  = data_q;
    if (in_ready_o) begin
      valid_d = in_valid_i;
      if (in_valid_i) begin
        op_d   = in_op_i;
        data_d = in_data_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      op_q    <= GATE_INV;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      op_q    <= op_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/gate_pipe_tb_top.sv
// Op-selectable gate datapath feeding a STAGES-deep elastic pipeline, with a
// saturating handshake counter. GATE_PIPE_SIG_EN adds the rotating-XOR result signature.
module gate_pipe_tb_top
  import gate_pkg::*;
#(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned STAGES = 2,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  gate_op_e         op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output gate_op_e         out_op,
  output logic [CNT_W-1:0] op_count
`ifdef GATE_PIPE_SIG_EN
  ,
  output logic [WIDTH-1:0] sig
`endif
);

  gate_word_t       a_ext, b_ext, r_ext;
  logic [WIDTH-1:0] gate_res;
  logic             out_hs;

  always_comb begin
    a_ext              = '0;
    a_ext[WIDTH-1:0]   = in1;
    b_ext              = '0;
    b_ext[WIDTH-1:0]   = in2;
    r_ext              = gate_eval(op, a_ext, b_ext, in3[0]);
  end

  assign gate_res = r_ext[WIDTH-1:0];

  // Only in3[0] selects; the extended upper result bits are discarded.
  logic unused_in3;
  logic unused_r_hi;
  assign unused_in3  = ^in3[WIDTH-1:1];
  assign unused_r_hi = ^r_ext[GATE_MAX_W-1:WIDTH];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic             up_valid, up_ready, dn_valid, dn_ready;
    gate_op_e         up_op, dn_op;
    logic [WIDTH-1:0] up_data, dn_data;

    if (k == 0) begin : g_head
      assign up_valid = in_valid;
      assign up_op    = op;
      assign up_data  = gate_res;
    end else begin : g_body
      assign up_valid = g_stage[k-1].dn_valid;
      assign up_op    = g_stage[k-1].dn_op;
      assign up_data  = g_stage[k-1].dn_data;
    end

    if (k == STAGES - 1) begin : g_tail
      assign dn_ready = out_ready;
    end else begin : g_link
      assign dn_ready = g_stage[k+1].up_ready;
    end

    gate_pipe_slice #(
      .Width(WIDTH)
    ) u_slice (
      .clk_i      (clk),
      .rst_i      (rst),
      .in_valid_i (up_valid),
      .in_ready_o (up_ready),
      .in_op_i    (up_op),
      .in_data_i  (up_data),
      .out_valid_o(dn_valid),
      .out_ready_i(dn_ready),
      .out_op_o   (dn_op),
      .out_data_o (dn_data)
    );
  end

  assign in_ready  = g_stage[0].up_ready;
  assign out_valid = g_stage[STAGES-1].dn_valid;
  assign out_op    = g_stage[STAGES-1].dn_op;
  assign out_data  = g_stage[STAGES-1].dn_data;
  assign out_hs    = out_valid && out_ready;

  logic [CNT_W-1:0] op_count_q, op_count_d;

  always_comb begin
    op_count_d = op_count_q;
    if (out_hs && (op_count_q != {CNT_W{1'b1}})) begin
      op_count_d = op_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_count_q <= '0;
    end else begin
      op_count_q <= op_count_d;
    end
  end

  assign op_count = op_count_q;

`ifdef GATE_PIPE_SIG_EN
  logic [WIDTH-1:0] sig_q, sig_d;

  always_comb begin
    sig_d = sig_q;
    if (out_hs) begin
      sig_d = {sig_q[WIDTH-2:0], sig_q[WIDTH-1]} ^ out_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;
`endif

endmodule

// File: tb/tb_gate_pipe_tb_top.sv
// Bench for gate_pipe_tb_top: queue-based reference model checked every cycle,
// directed literal checks, and randomized traffic with backpressure.
module tb_gate_pipe_tb_top;
  import gate_pkg::*;

  localparam int unsigned W  = 64;
  localparam int unsigned S  = 2;
  localparam int unsigned CW = 16;

  localparam logic [W-1:0] OPA = 64'hF0F0_F0F0_F0F0_F0F0;
  localparam logic [W-1:0] OPB = 64'hFF00_FF00_FF00_FF00;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, out_valid, out_ready;
  gate_op_e      op, out_op;
  logic [W-1:0]  in1, in2, in3, out_data;
  logic [CW-1:0] op_count;

  logic          s_in_ready, s_out_valid;
  gate_op_e      s_out_op;
  logic [W-1:0]  s_out_data;
  logic [3:0]    s_op_count;
`ifdef GATE_PIPE_SIG_EN
  logic [W-1:0]  sig, s_sig;
`endif

  always #5 clk = ~clk;

  gate_pipe_tb_top #(.WIDTH(W), .STAGES(S), .CNT_W(CW)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .in1(in1), .in2(in2), .in3(in3), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_op(out_op), .op_count(op_count)
`ifdef GATE_PIPE_SIG_EN
    , .sig(sig)
`endif
  );

  gate_pipe_tb_top #(.WIDTH(W), .STAGES(S), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .op(op),
    .in1(in1), .in2(in2), .in3(in3), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_data(s_out_data), .out_op(s_out_op), .op_count(s_op_count)
`ifdef GATE_PIPE_SIG_EN
    , .sig(s_sig)
`endif
  );

  typedef struct {
    logic [W-1:0] data;
    gate_op_e     op;
    int           acc;
  } item_t;

  item_t        q[$];
  item_t        it;
  int           cyc = 0;
  int           m_cnt = 0;
  logic [W-1:0] m_sig = '0;
  int           n_cmp = 0;
  int           n_fail = 0;
  bit           ev, er;

  function automatic logic [W-1:0] ref_gate(gate_op_e o, logic [W-1:0] a, logic [W-1:0] b,
                                            logic [W-1:0] s);
    case (o)
      GATE_INV:   return ~a;
      GATE_AND2:  return a & b;
      GATE_NAND2: return ~(a & b);
      default:    return s[0] ? b : a;
    endcase
  endfunction

  task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: in-flight ops in a queue; an op is visible S cycles after acceptance.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      m_cnt = 0;
      m_sig = '0;
      chk("rst_in_ready", W'(in_ready), W'(1'b1));
      chk("rst_out_valid", W'(out_valid), '0);
      chk("rst_op_count", W'(op_count), '0);
    end else begin
      ev = (q.size() > 0) && (cyc >= q[0].acc + int'(S));
      er = (q.size() < int'(S)) || out_ready;
      chk("in_ready", W'(in_ready), W'(er));
      chk("out_valid", W'(out_valid), W'(ev));
      if (ev) begin
        chk("out_data", out_data, q[0].data);
        chk("out_op", W'(out_op), W'(q[0].op));
      end
      chk("op_count", W'(op_count), W'(m_cnt));
      chk("sat_op_count", W'(s_op_count), W'((m_cnt > 15) ? 15 : m_cnt));
`ifdef GATE_PIPE_SIG_EN
      chk("sig", sig, m_sig);
`endif
      if (ev && out_ready) begin
        m_sig = {m_sig[W-2:0], m_sig[W-1]} ^ q[0].data;
        void'(q.pop_front());
        m_cnt++;
      end
      if (in_valid && er) begin
        it.data = ref_gate(op, in1, in2, in3);
        it.op   = op;
        it.acc  = cyc;
        q.push_back(it);
      end
    end
  end

  task automatic directed(gate_op_e o, logic [W-1:0] a, logic [W-1:0] b, logic [W-1:0] s,
                          logic [W-1:0] exp, string name);
    @(posedge clk); #1;
    in_valid = 1'b1; op = o; in1 = a; in2 = b; in3 = s;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (S - 1) @(posedge clk);
    @(negedge clk);
    chk({name, "_valid"}, W'(out_valid), W'(1'b1));
    chk(name, out_data, exp);
  endtask

  gate_op_e     st_op [4];
  int           idx, seen;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = GATE_INV;
    in1 = '0; in2 = '0; in3 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_data", out_data, '0);
    chk("rst_out_op", W'(out_op), '0);
    @(posedge clk); #1;
    rst = 1'b0;

    directed(GATE_INV,   OPA, OPB, '0, 64'h0F0F_0F0F_0F0F_0F0F, "inv");
    directed(GATE_AND2,  OPA, OPB, '0, 64'hF000_F000_F000_F000, "and2");
    directed(GATE_NAND2, OPA, OPB, '0, 64'h0FFF_0FFF_0FFF_0FFF, "nand2");
    directed(GATE_MUX2,  OPA, OPB, 64'd1, OPB, "mux2_sel1");
    directed(GATE_MUX2,  OPA, OPB, 64'd0, OPA, "mux2_sel0");

    // Back-to-back stream of 10 ops
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      in_valid = (i < 10);
      op  = gate_op_e'($urandom_range(0, 3));
      in1 = {$urandom, $urandom}; in2 = {$urandom, $urandom}; in3 = W'($urandom);
      @(negedge clk);
      if (i >= int'(S) && out_valid) seen++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("stream_valid_run", W'(seen), W'(10));
    chk("stream_op_count", W'(op_count), W'(15));

    // Stall: out_ready low while offering 4 ops
    st_op[0] = GATE_INV; st_op[1] = GATE_AND2; st_op[2] = GATE_NAND2; st_op[3] = GATE_MUX2;
    idx = 0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
      end
      in_valid = 1'b1; op = st_op[idx]; in1 = OPA; in2 = OPB; in3 = 64'd1;
      @(negedge clk);
      if (in_ready) idx++;
    end
    chk("stall_accepted", W'(idx), W'(2));
    chk("stall_in_ready", W'(in_ready), '0);
    chk("stall_frozen", out_data, 64'h0F0F_0F0F_0F0F_0F0F);
    chk("stall_out_op", W'(out_op), W'(GATE_INV));
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int c = 0; c < 20 && idx < 4; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
      end
      in_valid = 1'b1; op = st_op[idx]; in1 = OPA; in2 = OPB; in3 = 64'd1;
      @(negedge clk);
      if (in_ready) idx++;
    end
    chk("stall_all_sent", W'(idx), W'(4));
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("stall_op_count", W'(op_count), W'(19));
    chk("sat_after_19", W'(s_op_count), W'(15));

    // Reset with two ops in flight
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; op = GATE_AND2; in1 = {$urandom, $urandom}; in2 = '1; in3 = '0;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rstpulse_out_valid", W'(out_valid), '0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("rstpulse_op_count", W'(op_count), '0);

    directed(GATE_AND2, 64'd1, 64'd1, '0, 64'd1, "sig_res1");
    directed(GATE_AND2, 64'd2, 64'd3, '0, 64'd2, "sig_res2");
    @(posedge clk);
    @(negedge clk);
`ifdef GATE_PIPE_SIG_EN
    chk("sig_literal", sig, 64'h0);
`endif
    chk("sig_phase_count", W'(op_count), W'(2));

    // Randomized traffic with backpressure
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      op        = gate_op_e'($urandom_range(0, 3));
      in1       = {$urandom, $urandom};
      in2       = {$urandom, $urandom};
      in3       = {$urandom, $urandom};
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (S + 4) @(posedge clk);
    @(negedge clk);
    chk("final_out_valid", W'(out_valid), '0);
    chk("sat_final", W'(s_op_count), W'(15));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
